// File: rtl/seg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment patterns are active-low, bit 0 = a through bit 6 = g.
package seg_pkg;

    typedef logic [6:0] seg_pattern_t;

    // All segments dark.
    localparam seg_pattern_t SEG_OFF = 7'b1111111;

    // Hex glyphs 0-F, entry i at HEX_TABLE[i].
    localparam logic [15:0][6:0] HEX_TABLE = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h18,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

endpackage

// File: rtl/seg_decode.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] value,
    output logic [6:0] pattern
);

    // Straight table lookup; every nibble value has a glyph.
    always_comb begin
        pattern = HEX_TABLE[value];
    end

endmodule

// File: rtl/seg_mux_n.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// New data is double-buffered (shadow -> active) and only swapped at a
// frame boundary so a frame never shows a mix of old and new digits.
// Optional macro SEG_MUX_DEADTIME_EN blanks the first DEAD_CYCLES cycles
// of every slot to suppress ghosting while the digit drivers switch.
module seg_mux_n
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS  = 2,
    parameter int DIV_COUNT   = 240000,
    parameter int DEAD_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   digit_n,
    output logic                    frame_tick
);

    localparam int CW = $clog2(DIV_COUNT);
    localparam int IW = $clog2(NUM_DIGITS);
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV_COUNT - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

`ifdef SEG_MUX_DEADTIME_EN
    localparam int DEAD_LEN = DEAD_CYCLES;
`else
    // Dead time disabled: zero-length window, parameter has no effect.
    localparam int DEAD_LEN = 0 * DEAD_CYCLES;
`endif

    logic [CW-1:0]           cnt;
    logic [IW-1:0]           idx;
    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [4*NUM_DIGITS-1:0] active_digits;
    logic [NUM_DIGITS-1:0]   shadow_blank;
    logic [NUM_DIGITS-1:0]   active_blank;
    logic                    pending;
    logic                    wrap;
    logic                    wrap_q;
    logic [3:0]              nibble;
    logic [6:0]              lit_pattern;
    logic                    dark;

    assign wrap   = (cnt == CNT_LAST) && (idx == IDX_LAST);
    assign nibble = active_digits[{idx, 2'b00} +: 4];

    seg_decode u_decode (
        .value   (nibble),
        .pattern (lit_pattern)
    );

    // Slot cycle counter and digit index, advancing at terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= '0;
        end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (idx == IDX_LAST) begin
                idx <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Shadow capture on load; shadow-to-active swap only at frame wrap.
    // A load on the wrap cycle swaps in the old shadow and stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_digits <= '0;
            shadow_blank  <= '0;
            active_digits <= '0;
            active_blank  <= '0;
            pending       <= 1'b0;
            wrap_q        <= 1'b0;
        end else begin
            wrap_q <= wrap;
            if (wrap && pending) begin
                active_digits <= shadow_digits;
                active_blank  <= shadow_blank;
            end
            if (load) begin
                shadow_digits <= digits_in;
                shadow_blank  <= blank_in;
                pending       <= 1'b1;
            end else if (wrap) begin
                pending <= 1'b0;
            end
        end
    end

    // Digit is dark when masked or inside the slot's dead-time window.
    always_comb begin
        dark = active_blank[idx];
        if (int'(cnt) < DEAD_LEN) begin
            dark = 1'b1;
        end
    end

    // Registered outputs: pattern and enable for the current slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF;
            digit_n    <= '1;
            frame_tick <= 1'b0;
        end else begin
            frame_tick <= wrap_q;
            if (dark) begin
                seg     <= SEG_OFF;
                digit_n <= '1;
            end else begin
                seg     <= lit_pattern;
                digit_n <= ~({{(NUM_DIGITS-1){1'b0}}, 1'b1} << idx);
            end
        end
    end

endmodule

// File: tb/tb_seg_mux_n.sv
// Self-checking bench for seg_mux_n (NUM_DIGITS=2, DIV_COUNT=4,
// DEAD_CYCLES=1). Honours SEG_MUX_DEADTIME_EN when defined.
module tb_seg_mux_n;

    localparam int NUM_DIGITS  = 2;
    localparam int DIV_COUNT   = 4;
    localparam int DEAD_CYCLES = 1;
    localparam int FRAME       = NUM_DIGITS * DIV_COUNT;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] digits_in = '0;
    logic [1:0] blank_in = '0;
    logic       load = 1'b0;
    logic [6:0] seg;
    logic [1:0] digit_n;
    logic       frame_tick;

    int errors = 0;
    int checks = 0;

    // Reference model: what the display shows this frame and what is queued.
    int         cycles;
    logic [7:0] disp_digits;
    logic [1:0] disp_blank;
    logic [7:0] next_digits;
    logic [1:0] next_blank;
    bit         next_valid;

    seg_mux_n #(
        .NUM_DIGITS  (NUM_DIGITS),
        .DIV_COUNT   (DIV_COUNT),
        .DEAD_CYCLES (DEAD_CYCLES)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .digits_in  (digits_in),
        .blank_in   (blank_in),
        .load       (load),
        .seg        (seg),
        .digit_n    (digit_n),
        .frame_tick (frame_tick)
    );

    // Free-running clock, period 10.
    always #5 clk = ~clk;

    function automatic logic [6:0] hex_glyph(input logic [3:0] v);
        case (v)
            4'h0: return 7'b1000000;
            4'h1: return 7'b1111001;
            4'h2: return 7'b0100100;
            4'h3: return 7'b0110000;
            4'h4: return 7'b0011001;
            4'h5: return 7'b0010010;
            4'h6: return 7'b0000010;
            4'h7: return 7'b1111000;
            4'h8: return 7'b0000000;
            4'h9: return 7'b0011000;
            4'hA: return 7'b0001000;
            4'hB: return 7'b0000011;
            4'hC: return 7'b1000110;
            4'hD: return 7'b0100001;
            4'hE: return 7'b0000110;
            default: return 7'b0001110;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [6:0] observed,
                                input logic [6:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%b expected=%b at cycle %0d",
                   tag, observed, expected, cycles);
        end
    endtask

    task automatic model_reset();
        cycles      = 0;
        disp_digits = '0;
        disp_blank  = '0;
        next_digits = '0;
        next_blank  = '0;
        next_valid  = 0;
    endtask

    // One clock: drive inputs, predict outputs from the slot position, check.
    task automatic apply_stimulus(input logic ld, input logic [7:0] d,
                                  input logic [1:0] b);
        int         slot;
        int         in_slot;
        bit         dark;
        logic [6:0] exp_seg;
        logic [1:0] exp_dn;
        logic       exp_tick;
        load      = ld;
        digits_in = d;
        blank_in  = b;
        slot    = (cycles / DIV_COUNT) % NUM_DIGITS;
        in_slot = cycles % DIV_COUNT;
        dark    = disp_blank[slot];
`ifdef SEG_MUX_DEADTIME_EN
        if (in_slot < DEAD_CYCLES) dark = 1;
`endif
        exp_seg  = dark ? 7'b1111111 : hex_glyph(disp_digits[4*slot +: 4]);
        exp_dn   = dark ? 2'b11 : ~(2'b01 << slot);
        exp_tick = (cycles > 0) && (cycles % FRAME == 0);
        @(posedge clk);
        #1;
        check_output("seg", seg, exp_seg);
        check_output("digit_n", {5'b0, digit_n}, {5'b0, exp_dn});
        check_output("frame_tick", {6'b0, frame_tick}, {6'b0, exp_tick});
        cycles++;
        if (cycles % FRAME == 0 && next_valid) begin
            disp_digits = next_digits;
            disp_blank  = next_blank;
            next_valid  = 0;
        end
        if (ld) begin
            next_digits = d;
            next_blank  = b;
            next_valid  = 1;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            apply_stimulus(1'b0, 8'($urandom), 2'($urandom));
        end
    endtask

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_output("reset_seg", seg, 7'b1111111);
        check_output("reset_digit_n", {5'b0, digit_n}, 7'b0000011);
        check_output("reset_tick", {6'b0, frame_tick}, 7'b0);
        reset = 1'b0;

        idle(5);
        apply_stimulus(1'b1, 8'h4F, 2'b00);
        idle(20);

        while (cycles % FRAME != 3) idle(1);
        apply_stimulus(1'b1, 8'h99, 2'b00);
        idle(16);

        while (cycles % FRAME != 7) idle(1);
        apply_stimulus(1'b1, 8'h3A, 2'b00);
        idle(20);

        apply_stimulus(1'b1, 8'h5C, 2'b10);
        idle(20);

        for (int i = 0; i < 300; i++) begin
            apply_stimulus($urandom_range(0, 4) == 0, 8'($urandom), 2'($urandom));
        end

        apply_stimulus(1'b1, 8'h77, 2'b00);
        idle(2);
        load  = 1'b0;
        reset = 1'b1;
        #1;
        check_output("midreset_seg", seg, 7'b1111111);
        check_output("midreset_digit_n", {5'b0, digit_n}, 7'b0000011);
        check_output("midreset_tick", {6'b0, frame_tick}, 7'b0);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle(20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg_mux_n.md
SEG_MUX_N -- requirements
Module: seg_mux_n

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 2, number of multiplexed 7-segment digits (legal range 2..8).
REQ-002 SHALL have parameter DIV_COUNT, default 240000, clk cycles per digit slot (legal minimum 4).
REQ-003 SHALL have parameter DEAD_CYCLES, default 16, blanking cycles at the start of each slot (legal range 1..DIV_COUNT-2; used only when SEG_MUX_DEADTIME_EN is defined).
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port digits_in, input, 4*NUM_DIGITS, hex nibbles, with digit i at bits [4i+3:4i].
REQ-007 SHALL have port blank_in, input, NUM_DIGITS, per-digit blank mask (1 = digit dark).
REQ-008 SHALL have port load, input, 1, single-cycle strobe that captures digits_in and blank_in.
REQ-009 SHALL have port seg, output, 7, active-low segments, bit 0 = a through bit 6 = g.
REQ-010 SHALL have port digit_n, output, NUM_DIGITS, active-low one-hot digit enables for the transistor drivers.
REQ-011 SHALL have port frame_tick, output, 1, one-cycle pulse when digit index wraps to 0.

Function
REQ-012 SHALL count slot cycles 0..DIV_COUNT-1 and, at the terminal count, advance the digit index, wrapping from NUM_DIGITS-1 to 0.
REQ-013 SHALL register all outputs; seg and digit_n reflect the current index and active register one cycle after the index changes.
REQ-014 SHALL drive digit_n bit idx low and all other bits high; seg SHALL be the hex decode (0-F) of the active nibble idx.
REQ-015 SHALL capture digits_in and blank_in into a shadow register on any clk edge with load high, and set a pending flag.
REQ-016 SHALL copy shadow to active only at a frame boundary (index wrap to 0) while pending is set, then clear pending; there SHALL be no mid-frame tearing.
REQ-017 SHALL, when load coincides with a frame boundary, copy the pre-load shadow to active and keep pending set, so new data is shown on the following frame.
REQ-018 SHALL, for a blanked digit, drive seg = 7'b1111111 and all digit_n bits high for that whole slot.
REQ-019 SHALL assert frame_tick for exactly one cycle per frame, aligned with the cycle in which index 0 is first driven.

Reset
REQ-020 SHALL, while reset is high, force seg = 7'b1111111, all digit_n bits high, and frame_tick = 0.
REQ-021 SHALL, while reset is high, clear the slot counter, index, shadow, active, blank masks and pending to 0.
REQ-022 SHALL, on the first edge after release, drive digit 0 with value 0: digit_n = ~1 and seg = 7'b1000000.
REQ-023 SHALL, if reset is asserted mid-frame, discard any pending load.

Configuration
REQ-024 SHALL, with SEG_MUX_DEADTIME_EN defined, drive all digit_n bits high and seg = 7'b1111111 for the first DEAD_CYCLES cycles of every slot (anti-ghosting).
REQ-025 SHALL, without SEG_MUX_DEADTIME_EN, apply no dead time and ignore DEAD_CYCLES.

Structure
REQ-026 SHALL place the 16-entry hex-to-segment constant table and the SEG_OFF constant in the shared package seg_pkg.
REQ-027 SHALL contain one combinational sub-module, seg_decode, that maps a 4-bit value to a 7-bit active-low pattern.

Verification (NUM_DIGITS=2, DIV_COUNT=4, DEAD_CYCLES=1)
REQ-028 SHALL check: reset high -> seg=1111111, digit_n=11; after release, digit_n=10 and seg=1000000.
REQ-029 SHALL check: load with digits_in=8'h4F -> after the next frame_tick, slot 0 gives digit_n=10, seg=0001110 (F), and slot 1 gives digit_n=01, seg=0011001 (4).
REQ-030 SHALL check: load 8'h99 mid-frame -> remaining slots of that frame still show the old data; the next frame shows seg=0011000 on both digits.
REQ-031 SHALL check: load coincident with a frame boundary -> the new value is first shown one full frame later.
REQ-032 SHALL check: blank_in=2'b10 -> in slot 1, digit_n=11 and seg=1111111; slot 0 is unaffected.
REQ-033 SHALL check: with SEG_MUX_DEADTIME_EN defined -> the first cycle of each slot has digit_n=11, and frame_tick pulses every 8 cycles.
